// File: rtl/arith_dispatcher_if.sv
// arith_dispatcher_if: request/response handshake, shared operand bus and per-unit
// start/working/result lines between the arithmetic dispatcher and its environment.
//   req_*       : operation request (valid/ready), op code and operands
//   op_a/op_b   : operand bus broadcast to all units
//   *_start     : per-unit start (at most one high)
//   *_working   : per-unit busy indication
//   *_result    : per-unit result
//   resp_*      : response (valid/ready), data and error flag
//   busy        : dispatcher not idle
// Modports: slave = dispatcher side, master = environment (requester + units) side.
interface arith_dispatcher_if #(
  parameter int unsigned WIDTH = 64
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             add_start;
  logic             sub_start;
  logic             mul_start;
  logic             div_start;
  logic             add_working;
  logic             sub_working;
  logic             mul_working;
  logic             div_working;
  logic [WIDTH-1:0] add_result;
  logic [WIDTH-1:0] sub_result;
  logic [WIDTH-1:0] mul_result;
  logic [WIDTH-1:0] div_result;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_err;
  logic             busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  add_working, sub_working, mul_working, div_working,
    input  add_result, sub_result, mul_result, div_result,
    input  resp_ready,
    output req_ready, op_a, op_b,
    output add_start, sub_start, mul_start, div_start,
    output resp_valid, resp_data, resp_err, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    output add_working, sub_working, mul_working, div_working,
    output add_result, sub_result, mul_result, div_result,
    output resp_ready,
    input  req_ready, op_a, op_b,
    input  add_start, sub_start, mul_start, div_start,
    input  resp_valid, resp_data, resp_err, busy
  );
endinterface

// File: rtl/arith_dispatcher.sv
// arith_dispatcher: accepts one arithmetic request at a time, drives the shared operand
// bus, holds the selected unit's start for SETTLE cycles, captures that unit's result and
// returns it as a response. Divide-by-zero and unit conflicts are reported as errors.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : arith_dispatcher_if slave modport (request, operand bus, units, response)
module arith_dispatcher #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned SETTLE = 2
) (
  input logic              clk,
  input logic              rst_n,
  arith_dispatcher_if.slave bus
);

  localparam logic [3:0] CntLast = 4'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       start_q, start_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic [3:0]       working;
  logic [3:0]       target;
  logic [WIDTH-1:0] result_sel;

  assign working = {bus.div_working, bus.mul_working, bus.sub_working, bus.add_working};
  assign target  = 4'b0001 << op_q;

  always_comb begin
    result_sel = '0;
    unique case (op_q)
      2'd0: result_sel = bus.add_result;
      2'd1: result_sel = bus.sub_result;
      2'd2: result_sel = bus.mul_result;
      2'd3: result_sel = bus.div_result;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d  = bus.req_op;
          a_d   = bus.req_a;
          b_d   = bus.req_b;
          cnt_d = '0;
          if (bus.req_op == 2'd3 && bus.req_b == '0) begin
            // Divide-by-zero never reaches the divider.
            state_d = StResp;
            valid_d = 1'b1;
            err_d   = 1'b1;
            data_d  = '0;
          end else begin
            state_d = StIssue;
            start_d = 4'b0001 << bus.req_op;
          end
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CntLast) begin
          state_d = StResp;
          start_d = '0;
          valid_d = 1'b1;
          // Only the target may be working at capture; anything else is a conflict.
          if (working == target) begin
            data_d = result_sel;
            err_d  = 1'b0;
          end else begin
            data_d = '0;
            err_d  = 1'b1;
          end
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        start_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      start_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.op_a       = a_q;
  assign bus.op_b       = b_q;
  assign bus.add_start  = start_q[0];
  assign bus.sub_start  = start_q[1];
  assign bus.mul_start  = start_q[2];
  assign bus.div_start  = start_q[3];
  assign bus.resp_valid = valid_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_arith_dispatcher.sv
// tb_arith_dispatcher: directed stimulus with literal expectations per operation, plus a
// cycle-timestamp model of the dispatcher compared against the DUT on every falling edge.
module tb_arith_dispatcher;

  localparam int unsigned W = 64;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  logic [3:0] frc = '0;
  int n_chk = 0;
  int n_err = 0;

  arith_dispatcher_if #(.WIDTH(W)) bus ();

  arith_dispatcher #(.WIDTH(W), .SETTLE(S)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Unit models: working while started (or when forced), result is plain arithmetic.
  assign bus.add_working = bus.add_start | frc[0];
  assign bus.sub_working = bus.sub_start | frc[1];
  assign bus.mul_working = bus.mul_start | frc[2];
  assign bus.div_working = bus.div_start | frc[3];
  assign bus.add_result  = bus.op_a + bus.op_b;
  assign bus.sub_result  = bus.op_a - bus.op_b;
  assign bus.mul_result  = bus.op_a * bus.op_b;
  assign bus.div_result  = (bus.op_b == '0) ? '0 : bus.op_a / bus.op_b;

  logic [3:0] starts;
  logic [3:0] works;
  assign starts = {bus.div_start, bus.mul_start, bus.sub_start, bus.add_start};
  assign works  = {bus.div_working, bus.mul_working, bus.sub_working, bus.add_working};

  function automatic logic [63:0] arith(input logic [1:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return (b == 64'd0) ? 64'd0 : a / b;
    endcase
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] op);
    logic [3:0] v;
    v = '0;
    v[op] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: operation accepted in cycle acc; starts in acc+1..acc+S; response valid from
  // acc+S+1 (acc+1 for divide-by-zero) until the cycle resp_ready is seen.
  int         cyc = 0;
  logic       m_busy = 1'b0;
  int         m_acc = 0;
  logic [1:0] m_op = '0;
  logic       m_divz = 1'b0;
  logic [63:0] m_opa = '0, m_opb = '0, m_data = '0;
  logic       m_err = 1'b0;

  function automatic int resp_from();
    return m_divz ? m_acc + 1 : m_acc + S + 1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_opa  <= '0;
      m_opb  <= '0;
      m_data <= '0;
      m_err  <= 1'b0;
    end else if (!m_busy) begin
      if (bus.req_valid) begin
        m_busy <= 1'b1;
        m_acc  <= cyc;
        m_op   <= bus.req_op;
        m_opa  <= bus.req_a;
        m_opb  <= bus.req_b;
        m_divz <= (bus.req_op == 2'd3 && bus.req_b == '0);
        if (bus.req_op == 2'd3 && bus.req_b == '0) begin
          m_err  <= 1'b1;
          m_data <= '0;
        end
      end
    end else if (!m_divz && cyc == m_acc + S) begin
      if (works == onehot(m_op)) begin
        m_err  <= 1'b0;
        m_data <= arith(m_op, m_opa, m_opb);
      end else begin
        m_err  <= 1'b1;
        m_data <= '0;
      end
    end else if (cyc >= resp_from() && bus.resp_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic       exp_valid;
      logic [3:0] exp_starts;
      exp_valid  = m_busy && cyc >= resp_from();
      exp_starts = (m_busy && !m_divz && cyc >= m_acc + 1 && cyc <= m_acc + S) ?
                   onehot(m_op) : 4'b0000;
      chk("cyc_starts", 64'(starts), 64'(exp_starts));
      chk("cyc_onehot", 64'($countones(starts) <= 1), 64'd1);
      chk("cyc_resp_valid", 64'(bus.resp_valid), 64'(exp_valid));
      chk("cyc_req_ready", 64'(bus.req_ready), 64'(!m_busy));
      chk("cyc_busy", 64'(bus.busy), 64'(m_busy));
      chk("cyc_resp_data", bus.resp_data, m_data);
      chk("cyc_resp_err", 64'(bus.resp_err), 64'(m_err));
      chk("cyc_op_a", bus.op_a, m_opa);
      chk("cyc_op_b", bus.op_b, m_opb);
    end
  end

  // Issue one request from idle, wait (bounded) for its response, hold backpressure for bp
  // cycles, then complete the handshake. Returns idle, just after a rising edge.
  task automatic send(input string name, input logic [1:0] op, input logic [63:0] a,
                      input logic [63:0] b, input int bp, input logic [63:0] exp_data,
                      input logic exp_err, input int exp_lat);
    int lat;
    int n_start;
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.resp_ready = (bp == 0);
    chk({name, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    n_start = 0;
    while (!bus.resp_valid && lat < 50) begin
      if (starts[op]) n_start++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_start_cycles"}, 64'(n_start), 64'(exp_lat - 1));
    for (int i = 0; i < bp; i++) begin
      chk({name, "_bp_valid"}, 64'(bus.resp_valid), 64'd1);
      chk({name, "_bp_data"}, bus.resp_data, exp_data);
      chk({name, "_bp_req_ready"}, 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    chk({name, "_data"}, bus.resp_data, exp_data);
    chk({name, "_err"}, 64'(bus.resp_err), 64'(exp_err));
    @(posedge clk);
    #1;
    chk({name, "_busy_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_starts", 64'(starts), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_data", bus.resp_data, 64'd0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
    chk("rst_op_a", bus.op_a, 64'd0);
    chk("rst_op_b", bus.op_b, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);

    send("sub", 2'd1, 64'd100, 64'd58, 0, 64'd42, 1'b0, S + 1);
    send("bp_mul", 2'd2, 64'd7, 64'd6, 5, 64'd42, 1'b0, S + 1);
    send("divz", 2'd3, 64'd9, 64'd0, 0, 64'd0, 1'b1, 1);

    frc = 4'b0100;
    send("conflict", 2'd0, 64'd5, 64'd6, 0, 64'd0, 1'b1, S + 1);
    frc = 4'b0000;

    // Reset in the second ISSUE cycle aborts the add.
    bus.req_valid  = 1'b1;
    bus.req_op     = 2'd0;
    bus.req_a      = 64'd1;
    bus.req_b      = 64'd2;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_issuing", 64'(bus.add_start), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_starts", 64'(starts), 64'd0);
    chk("midrst_valid", 64'(bus.resp_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("midrst_valid_after", 64'(bus.resp_valid), 64'd0);
    send("add_after_rst", 2'd0, 64'd3, 64'd4, 0, 64'd7, 1'b0, S + 1);

    send("b2b_add", 2'd0, 64'd10, 64'd20, 0, 64'd30, 1'b0, S + 1);
    send("b2b_sub", 2'd1, 64'd9, 64'd4, 0, 64'd5, 1'b0, S + 1);
    send("b2b_mul", 2'd2, 64'd6, 64'd7, 0, 64'd42, 1'b0, S + 1);
    send("b2b_div", 2'd3, 64'd100, 64'd7, 0, 64'd14, 1'b0, S + 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/arith_dispatcher.md
# arith_dispatcher

Sequencer that sits directly upstream of the four peer arithmetic units (add, sub, mul, div). It accepts one operation request at a time over a valid/ready interface and drives the shared operand bus. It raises the selected unit's `start` for a fixed settle window, captures that unit's result, and returns it over a valid/ready response interface. It guarantees that at most one unit `start` is ever high, which the peer ack handshake between the units requires.

## Interface
Parameters:
- `WIDTH`, 64, operand/result width.
- `SETTLE`, 2, cycles `start` is held before capture; legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: dispatcher can accept.
- `req_op` in 2: operation code. 0=add, 1=sub, 2=mul, 3=div.
- `req_a`, `req_b` in WIDTH: operands.
- `op_a`, `op_b` out WIDTH: registered operand bus to all units.
- `add_start`, `sub_start`, `mul_start`, `div_start` out 1: unit starts, one-hot or zero.
- `add_working`, `sub_working`, `mul_working`, `div_working` in 1: unit busy indications.
- `add_result`, `sub_result`, `mul_result`, `div_result` in WIDTH: unit results.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts.
- `resp_data` out WIDTH: captured result.
- `resp_err` out 1: response is an error; `resp_data`=0.
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, ISSUE, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: register op, a, b; clear the settle counter.
  - If op=3 and b=0: go to RESP with `resp_err`=1, `resp_data`=0. No start is issued.
  - Otherwise go to ISSUE.
- **ISSUE**
  - The start for the registered op is high; all other starts are low.
  - `op_a`/`op_b` hold the registered operands.
  - The counter increments every cycle.
  - On the cycle the counter equals SETTLE-1, evaluate:
    - Target `_working`=1 and all other `_working`=0: capture the target result into `resp_data`, `resp_err`=0.
    - Otherwise (target not working, or any peer working): `resp_err`=1, `resp_data`=0.
  - Then go to RESP. The start drops in the same transition.
- **RESP**
  - `resp_valid`=1; `resp_data`/`resp_err` are stable.
  - On `resp_ready`, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- `op_a`/`op_b` keep their last value in IDLE and RESP. They update only on request accept.
- Arithmetic is done entirely by the units. The dispatcher never modifies result bits; width is passed through unchanged.

## Timing
- Reset (`rst_n`=0 sampled at a rising edge):
  - State goes to IDLE.
  - Reset values: all starts 0, `resp_valid` 0, `resp_data` 0, `resp_err` 0, `op_a`/`op_b` 0, `busy` 0.
  - `req_ready` is 1 from the first cycle after reset is released.
- Reset mid-ISSUE or mid-RESP aborts the operation: the start drops on the next edge and the response is discarded.
- Accept at edge N:
  - Start is high for cycles N+1 .. N+SETTLE.
  - `resp_valid` is high from edge N+SETTLE+1.
  - Minimum request-to-response latency is SETTLE+1 cycles; divide-by-zero is 1 cycle.
- Throughput: one operation per SETTLE+2 cycles at best, because RESP→IDLE costs one cycle.
- Response backpressure: RESP holds indefinitely while `resp_ready`=0, and the response stays stable the whole time.
- All outputs are registered except `req_ready` and `busy`, which are decoded from state.
- Unit inputs are sampled only on the capture cycle. Peer `_working` at any other time is ignored.

## Test plan
- **Sub:** reset, then `req_op`=1, a=100, b=58, SETTLE=2, with a model sub unit that sets `sub_working`=1 while started. Require `sub_start` high for exactly 2 cycles, `resp_valid` at accept+3, `resp_data`=42, `resp_err`=0, all other starts 0 throughout.
- **Backpressure:** `req_op`=2, a=7, b=6, `resp_ready` held 0 for 5 cycles. Require `resp_valid`=1 and `resp_data`=42 stable for all 5 cycles, `req_ready`=0. On `resp_ready`=1, `busy` drops on the next cycle.
- **Div by zero:** `req_op`=3, a=9, b=0. Require no `div_start` pulse, `resp_valid` at accept+1, `resp_err`=1, `resp_data`=0.
- **Conflict:** `req_op`=0 with `mul_working` forced 1 during ISSUE. Require `resp_err`=1, `resp_data`=0, `add_start` still dropped after 2 cycles.
- **Reset mid-op:** `rst_n`=0 in the 2nd ISSUE cycle. Require all starts 0, `resp_valid` 0 and `req_ready` 1 after release. A following add of 3+4 returns 7.
- **Back-to-back:** 4 requests (add, sub, mul, div) with `resp_ready` tied 1. Require responses in order with correct values and at most one start high in any cycle.
